// File: rtl/conv_encoder_k7.sv
// Rate-1/2 feed-forward convolutional encoder with optional K-1 zero tail per frame.
// Single-entry registered output stage; in_ready is combinational from the output stage and FSM.
module conv_encoder_k7 #(
    parameter int unsigned  K       = 7,
    parameter logic [K-1:0] G0      = 7'o171,
    parameter logic [K-1:0] G1      = 7'o133,
    parameter bit           TAIL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_bit,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_sym,
    output logic         out_last,
    output logic [K-2:0] enc_state,
    output logic         busy
);

    localparam int unsigned CW = (K > 2) ? $clog2(K - 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_TAIL
    } state_t;

    state_t        r_state;
    logic [K-2:0]  r_sr;
    logic [CW-1:0] r_tail_cnt;
    logic          r_out_valid;
    logic [1:0]    r_out_sym;
    logic          r_out_last;

    logic          w_adv;
    logic          w_accept;
    logic          w_bit;
    logic          w_term;
    logic [K-1:0]  w_win;
    logic [1:0]    w_sym;

    always_comb begin
        w_adv    = !r_out_valid || out_ready;
        in_ready = !rst && w_adv && (r_state != S_TAIL);
        w_accept = in_valid && in_ready;
        // Tail steps shift in zero; the data path only contributes on an accept.
        w_bit    = w_accept && in_bit;
        w_term   = !TAIL_EN && in_last;
        w_win    = {w_bit, r_sr};
        w_sym    = {^(w_win & G0), ^(w_win & G1)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_tail_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_sym   <= '0;
            r_out_last  <= 1'b0;
        end else if (w_adv) begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_sym   <= w_sym;
                r_out_last  <= w_term;
                r_sr        <= w_term ? '0 : w_win[K-1:1];
                if (!in_last) begin
                    r_state <= S_DATA;
                end else if (TAIL_EN) begin
                    r_state    <= S_TAIL;
                    r_tail_cnt <= CW'(K - 2);
                end else begin
                    r_state <= S_IDLE;
                end
            end else if (r_state == S_TAIL) begin
                r_out_valid <= 1'b1;
                r_out_sym   <= w_sym;
                r_out_last  <= (r_tail_cnt == '0);
                r_sr        <= w_win[K-1:1];
                if (r_tail_cnt == '0) begin
                    r_state <= S_IDLE;
                end else begin
                    r_tail_cnt <= r_tail_cnt - 1'b1;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_sym   = r_out_sym;
    assign out_last  = r_out_last;
    assign enc_state = r_sr;
    assign busy      = (r_state != S_IDLE) || r_out_valid;

endmodule

// File: tb/tb_conv_encoder_k7.sv
// Bench for conv_encoder_k7: directed and randomized frames on a tailed and an untailed instance,
// checked against a convolution-sum reference model.
module tb_conv_encoder_k7;

    localparam logic [6:0] M_G0 = 7'o171;
    localparam logic [6:0] M_G1 = 7'o133;

    logic       clk;
    logic       rst;
    logic       out_ready;

    logic       a_in_valid, a_in_ready, a_in_bit, a_in_last;
    logic       a_out_valid, a_out_last, a_busy;
    logic [1:0] a_out_sym;
    logic [5:0] a_enc_state;

    logic       b_in_valid, b_in_ready, b_in_bit, b_in_last;
    logic       b_out_valid, b_out_last, b_busy;
    logic [1:0] b_out_sym;
    logic [5:0] b_enc_state;

    int         n_checks = 0;
    int         n_errors = 0;
    int         rdy_mode = 0;

    bit         frame_q[$];
    logic [2:0] exp_q[$];
    logic [2:0] got_a[$];
    logic [2:0] got_b[$];
    int         rd_a = 0;
    int         rd_b = 0;

    conv_encoder_k7 #(.TAIL_EN(1'b1)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bit(a_in_bit), .in_last(a_in_last),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_sym(a_out_sym), .out_last(a_out_last),
        .enc_state(a_enc_state), .busy(a_busy)
    );

    conv_encoder_k7 #(.TAIL_EN(1'b0)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bit(b_in_bit), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_sym(b_out_sym), .out_last(b_out_last),
        .enc_state(b_enc_state), .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every symbol handed downstream, as {last, sym}.
    always @(negedge clk) begin
        if (a_out_valid && out_ready) got_a.push_back({a_out_last, a_out_sym});
        if (b_out_valid && out_ready) got_b.push_back({b_out_last, b_out_sym});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance to just after the next rising edge and choose out_ready for the coming cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    endtask

    task automatic drive(input bit sel, input bit v, input bit b, input bit l);
        if (sel) begin
            b_in_valid = v; b_in_bit = b; b_in_last = l;
        end else begin
            a_in_valid = v; a_in_bit = b; a_in_last = l;
        end
    endtask

    task automatic send_bit(input bit sel, input bit b, input bit l);
        bit acc;
        acc = 1'b0;
        drive(sel, 1'b1, b, l);
        for (int t = 0; t < 500 && !acc; t++) begin
            @(negedge clk);
            acc = sel ? b_in_ready : a_in_ready;
            tick();
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
        check("send_accept", acc, 1);
    endtask

    task automatic send_frame(input bit sel, input int gap_pct);
        for (int i = 0; i < frame_q.size(); i++) begin
            if ($urandom_range(0, 99) < gap_pct) repeat ($urandom_range(1, 3)) tick();
            send_bit(sel, frame_q[i], i == frame_q.size() - 1);
        end
    endtask

    task automatic rand_frame(input int len);
        frame_q.delete();
        repeat (len) frame_q.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic wait_idle(input bit sel);
        bit idle;
        idle = 1'b0;
        for (int t = 0; t < 400 && !idle; t++) begin
            @(negedge clk);
            idle = sel ? !b_busy : !a_busy;
            tick();
        end
        check(sel ? "idle_b" : "idle_a", idle, 1);
    endtask

    // Reference: each symbol is the GF(2) convolution of the zero-padded bit sequence with the generators.
    task automatic gen_exp(input bit tail);
        bit x[$];
        x = frame_q;
        if (tail) for (int i = 0; i < 6; i++) x.push_back(1'b0);
        for (int n = 0; n < x.size(); n++) begin
            bit s1, s0;
            s1 = 1'b0;
            s0 = 1'b0;
            for (int j = 0; j < 7; j++) begin
                if (n - j >= 0) begin
                    s1 ^= M_G0[6-j] & x[n-j];
                    s0 ^= M_G1[6-j] & x[n-j];
                end
            end
            exp_q.push_back({(n == x.size() - 1), s1, s0});
        end
    endtask

    task automatic compare_stream(input bit sel, input string tag);
        int base, avail;
        logic [2:0] g;
        base  = sel ? rd_b : rd_a;
        avail = (sel ? got_b.size() : got_a.size()) - base;
        check({tag, "_count"}, avail, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < avail; i++) begin
            g = sel ? got_b[base+i] : got_a[base+i];
            check(tag, {i[15:0], 13'd0, g}, {i[15:0], 13'd0, exp_q[i]});
        end
        if (sel) rd_b += avail; else rd_a += avail;
        exp_q.delete();
    endtask

    initial begin
        logic [2:0] imp_ref [7];
        logic [2:0] b3_ref  [3];
        logic [2:0] g;
        logic [1:0] held;
        int cnt, avail;

        imp_ref = '{3'b011, 3'b010, 3'b011, 3'b011, 3'b000, 3'b001, 3'b111};
        b3_ref  = '{3'b011, 3'b010, 3'b100};

        rst = 1'b1; out_ready = 1'b1; rdy_mode = 0;
        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);

        // Reset state
        @(negedge clk);
        check("rst_in_ready_a", a_in_ready, 0);
        check("rst_in_ready_b", b_in_ready, 0);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_sym", a_out_sym, 0);
        check("rst_out_last", a_out_last, 0);
        check("rst_enc_state", a_enc_state, 0);
        check("rst_busy", a_busy, 0);
        check("rst_in_ready_rel", a_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        tick();

        // Impulse
        frame_q = {1'b1};
        gen_exp(1);
        send_frame(0, 0);
        wait_idle(0);
        for (int i = 0; i < 7; i++) begin
            g = got_a[rd_a+i];
            check("impulse_lit", g, imp_ref[i]);
        end
        check("impulse_state", a_enc_state, 0);
        compare_stream(0, "impulse");

        // All-zero 4-bit frame, tail cycle count
        frame_q = {1'b0, 1'b0, 1'b0, 1'b0};
        gen_exp(1);
        send_frame(0, 0);
        cnt = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (a_in_ready) break;
            cnt++;
            tick();
        end
        tick();
        check("zero_tail_cycles", cnt, 6);
        wait_idle(0);
        check("zero_last_sym", got_a[rd_a+9], 3'b100);
        compare_stream(0, "zeros");

        // All-ones 12-bit frame
        rand_frame(0);
        repeat (12) frame_q.push_back(1'b1);
        gen_exp(1);
        send_frame(0, 0);
        wait_idle(0);
        for (int i = 6; i < 12; i++) begin
            g = got_a[rd_a+i];
            check("ones_steady", g[1:0], 2'b11);
        end
        check("ones_state", a_enc_state, 0);
        compare_stream(0, "ones");

        // Backpressure mid-frame with in_valid held
        rand_frame(8);
        gen_exp(1);
        for (int i = 0; i < 4; i++) send_bit(0, frame_q[i], 1'b0);
        drive(0, 1'b1, frame_q[4], 1'b0);
        rdy_mode  = 2;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            held = exp_q[3][1:0];
            check("bp_in_ready", a_in_ready, 0);
            check("bp_out_valid", a_out_valid, 1);
            check("bp_out_sym", a_out_sym, held);
            tick();
        end
        rdy_mode  = 0;
        out_ready = 1'b1;
        for (int i = 4; i < 8; i++) send_bit(0, frame_q[i], i == 7);
        wait_idle(0);
        compare_stream(0, "bp");

        // Reset after the second tail symbol is pushed
        frame_q = {1'b1};
        gen_exp(1);
        send_bit(0, 1'b1, 1'b1);
        tick(); tick();
        rst = 1'b1;
        @(negedge clk);
        check("mt_in_ready_rst", a_in_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("mt_out_valid", a_out_valid, 0);
        check("mt_enc_state", a_enc_state, 0);
        check("mt_busy", a_busy, 0);
        check("mt_out_last", a_out_last, 0);
        tick(); tick(); tick();
        avail = got_a.size() - rd_a;
        check("mt_count", avail, 3);
        for (int i = 0; i < 3 && i < avail; i++) begin
            g = got_a[rd_a+i];
            check("mt_sym", g, exp_q[i]);
        end
        rd_a += avail;
        exp_q.delete();
        frame_q = {1'b1};
        gen_exp(1);
        send_frame(0, 0);
        wait_idle(0);
        compare_stream(0, "mt_impulse");

        // Randomized back-to-back frames with random backpressure, tailed
        rdy_mode = 1;
        for (int f = 0; f < 8; f++) begin
            rand_frame($urandom_range(1, 16));
            gen_exp(1);
            send_frame(0, 25);
        end
        wait_idle(0);
        check("rand_a_state", a_enc_state, 0);
        compare_stream(0, "rand_a");

        // Untailed: 1,0,1
        rdy_mode = 0;
        frame_q = {1'b1, 1'b0, 1'b1};
        gen_exp(0);
        send_frame(1, 0);
        wait_idle(1);
        for (int i = 0; i < 3; i++) begin
            g = got_b[rd_b+i];
            check("b101_lit", g, b3_ref[i]);
        end
        check("b101_state", b_enc_state, 0);
        compare_stream(1, "b101");

        // Untailed randomized frames
        rdy_mode = 1;
        for (int f = 0; f < 8; f++) begin
            rand_frame($urandom_range(1, 12));
            gen_exp(0);
            send_frame(1, 25);
        end
        wait_idle(1);
        check("rand_b_state", b_enc_state, 0);
        compare_stream(1, "rand_b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
